dmux_stream_1xn: RTL
====================

Name: dmux_stream_1xn

Overview:
Parametrised registered 1-to-N demultiplexer for valid/ready streams; successor to the combinational 1x4 demux. Routes a W-bit word from one upstream source to one of N downstream channels selected per word, or to all channels in broadcast mode. Each channel has a one-entry output register with independent backpressure. Out-of-range selects are dropped and counted. Sits between a single producer and N consumer blocks in the datapath.

Parameters:
N, 4, number of output channels (N >= 2)
W, 8, data width in bits
CW, 8, width of the saturating drop counter
SW, $clog2(N), select width (derived; not overridden)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  upstream word valid
in_ready  output  1  block can accept the word this cycle
in_sel  input  SW  destination channel index
in_bcast  input  1  broadcast: word goes to every channel; in_sel ignored
in_data  input  W  upstream data
out_valid  output  N  bit k: channel k register holds a word
out_ready  input  N  bit k: channel k consumer accepts this cycle
out_data  output  N*W  channel k data on bits [k*W +: W]
drop_cnt  output  CW  count of dropped words, saturating

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset: all out_valid = 0, all out_data lanes = 0, drop_cnt = 0. Reset mid-operation discards held words; no partial state survives.
- Per channel k: v[k], d[k] registers; out_valid[k] = v[k]; out_data lane k = d[k].
- free[k] = !v[k] | out_ready[k]. A word held while out_ready[k]=0 stays stable, with out_data unchanged, until consumed.
- in_ready (combinational):
  - in_bcast=1: AND of free[0..N-1]
  - in_bcast=0, in_sel < N: free[in_sel]
  - in_bcast=0, in_sel >= N: 1 (drop path)
- Transfer occurs when in_valid & in_ready. in_sel, in_bcast and in_data are sampled only at transfer.
- Latency: 1 cycle. A word accepted in cycle t is on out_valid/out_data in cycle t+1.
- Channel update per cycle:
  - load (transfer targets k): v[k] <= 1, d[k] <= in_data. This covers simultaneous drain and load, giving back-to-back full throughput.
  - else if v[k] & out_ready[k]: v[k] <= 0. d[k] holds its last value.
  - else: hold.
- Broadcast loads all N channels in the same cycle. It is all-or-nothing: no channel is loaded unless all are free.
- Drop: a transfer with in_bcast=0 and in_sel >= N (only possible when N is not a power of 2) changes no channel. drop_cnt += 1, saturating at 2^CW-1.
- out_ready for a channel with v[k]=0 has no effect.
- Words to one channel leave in acceptance order. There are no ordering guarantees across channels.
- in_valid may drop without a transfer; no state changes in that case.
- No combinational path from in_valid/in_data to out_*. in_ready depends combinationally on out_ready, in_sel and in_bcast.

Test Plan:
- Reset: hold rst=1 for 2 cycles with random inputs -> out_valid=0000, every out_data lane 00, drop_cnt=0; after release with no traffic, in_ready=1.
- Unicast and backpressure (N=4, W=8): in_sel=2, in_data=A5, in_valid=1 for 1 cycle, out_ready=0000 -> next cycle out_valid=0100, lane2=A5, held stable for 5 cycles. Then present sel=2, data=5A -> in_ready=0. Raise out_ready[2] -> in_ready=1 the same cycle; next cycle out_valid=0100, lane2=5A.
- Streaming: sel=1, data 01,02,03,04 on consecutive cycles, out_ready=1111 -> in_ready stays 1; lane1 shows 01..04 on consecutive cycles starting 1 cycle after the first transfer.
- Broadcast: in_bcast=1, data=3C, all channels empty -> next cycle out_valid=1111, all lanes 3C. With channel 1 full and out_ready[1]=0, broadcast gives in_ready=0 and no channel changes.
- Drop (N=5, SW=3): in_sel=6, in_valid=1 -> in_ready=1, out_valid unchanged, drop_cnt=1. After 300 drops with CW=8 -> drop_cnt=255 and it stays 255.
- Reset mid-operation: out_valid=0101, assert rst for 1 cycle -> next cycle out_valid=0000 and drop_cnt=0. Then a random 10k-cycle run with random out_ready and a per-channel scoreboard shows no loss, duplication or reordering.

Source files
------------

// File: rtl/dmux_stream_1xn.sv
// dmux_stream_1xn
//   Registered 1-to-N demultiplexer for valid/ready streams. Each word is
//   routed to channel in_sel, or to every channel when in_bcast is set. Each
//   channel owns a one-entry output register with its own backpressure.
//   Words addressed to a non-existent channel (in_sel >= N, possible only
//   when N is not a power of two) are accepted, discarded and counted in a
//   saturating drop counter.
//
// Parameters
//   N   number of output channels (>= 2)
//   W   data width
//   CW  drop counter width
//   SW  select width, derived from N
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous reset, active-high
//   in_valid   upstream word valid
//   in_ready   block can accept the upstream word this cycle
//   in_sel     destination channel index
//   in_bcast   broadcast to all channels (in_sel ignored)
//   in_data    upstream data
//   out_valid  bit k: channel k register holds a word
//   out_ready  bit k: channel k consumer accepts this cycle
//   out_data   channel k data on bits [k*W +: W]
//   drop_cnt   saturating count of dropped words
module dmux_stream_1xn #(
  parameter  int unsigned N  = 4,
  parameter  int unsigned W  = 8,
  parameter  int unsigned CW = 8,
  localparam int unsigned SW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SW-1:0]   in_sel,
  input  logic            in_bcast,
  input  logic [W-1:0]    in_data,
  output logic [N-1:0]    out_valid,
  input  logic [N-1:0]    out_ready,
  output logic [N*W-1:0]  out_data,
  output logic [CW-1:0]   drop_cnt
);

  logic [N-1:0]   v_q, v_d;
  logic [N*W-1:0] d_q, d_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [N-1:0]   free;
  logic [N-1:0]   sel_hit;
  logic [N-1:0]   load;
  logic           sel_ok;
  logic           xfer;
  logic           drop;

  // One-hot decode of in_sel; all-zero means the index is out of range,
  // which avoids indexing a vector past its end.
  always_comb begin
    sel_hit = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sel_hit[k] = (in_sel == k[SW-1:0]);
    end
  end

  assign sel_ok = |sel_hit;
  assign free   = ~v_q | out_ready;

  always_comb begin
    if (in_bcast) begin
      in_ready = &free;
    end else if (sel_ok) begin
      in_ready = |(sel_hit & free);
    end else begin
      in_ready = 1'b1;
    end
  end

  assign xfer = in_valid & in_ready;
  assign drop = xfer & ~in_bcast & ~sel_ok;

  always_comb begin
    load = '0;
    for (int unsigned k = 0; k < N; k++) begin
      load[k] = xfer & (in_bcast | sel_hit[k]);
    end
  end

  // Load takes priority over drain so a consumed word can be replaced in
  // the same cycle; a drained register keeps its last data.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    for (int unsigned k = 0; k < N; k++) begin
      if (load[k]) begin
        v_d[k]         = 1'b1;
        d_d[k*W +: W]  = in_data;
      end else if (v_q[k] && out_ready[k]) begin
        v_d[k] = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (drop && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      d_q   <= '0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      d_q   <= d_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = v_q;
  assign out_data  = d_q;
  assign drop_cnt  = cnt_q;

endmodule
